hb_up_serializer: RTL and testbench

Merges periodic upstream heartbeats into the FPGA→PC upstream word stream. Consumes the heartbeat pulse and wall-clock time from the time manager. On each pulse it snapshots the 48-bit time and emits it as two atomic 32-bit words on the upstream channel. Ordinary upstream traffic passes through a single registered output stage. Heartbeats take priority over that traffic.

---
 rtl/hb_up_serializer.sv | 138 +++++++++++++
 tb/tb_hb_up_serializer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hb_up_serializer.sv
// Upstream heartbeat serializer: snapshots wall-clock time on a heartbeat pulse
// and emits it as an atomic LO/HI word pair ahead of ordinary upstream traffic.
module hb_up_serializer #(
    parameter int         Ntime      = 48,
    parameter int         Nout       = 32,
    parameter logic [7:0] HB_LO_CODE = 8'hE0,
    parameter logic [7:0] HB_HI_CODE = 8'hE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send_HB_up_pulse,
    input  logic [Ntime-1:0] time_elapsed,
    input  logic             hb_en,
    input  logic [Nout-1:0]  up_in_d,
    input  logic             up_in_v,
    output logic             up_in_a,
    output logic [Nout-1:0]  up_out_d,
    output logic             up_out_v,
    input  logic             up_out_a,
    output logic [7:0]       hb_drop_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        SEND_HI = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [47:0]       hb_time_q, hb_time_d;
    logic              hb_pending_q, hb_pending_d;
    logic [Nout-1:0]   up_out_d_q, up_out_d_d;
    logic              up_out_v_q, up_out_v_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic              free;
    logic              load_lo;
    logic              load_hi;
    logic              load_data;
    logic              hb_req;
    logic              hb_accept;
    logic              hb_drop;
    logic [47:0]       time_ext;

    assign time_ext = 48'(time_elapsed);
    assign free     = !up_out_v_q || up_out_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_lo) state_d = SEND_HI;
            SEND_HI: if (load_hi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Data is only accepted when no heartbeat is queued or in flight, which
    // keeps the LO/HI pair contiguous on the output.
    always_comb begin
        load_lo   = 1'b0;
        load_hi   = 1'b0;
        up_in_a   = 1'b0;
        case (state_q)
            IDLE: begin
                load_lo = free && hb_pending_q;
                up_in_a = free && !hb_pending_q;
            end
            SEND_HI: begin
                load_hi = free;
            end
            default: ;
        endcase
        load_data = up_in_a && up_in_v;
    end

    always_comb begin
        up_out_d_d = up_out_d_q;
        up_out_v_d = up_out_v_q;
        if (load_lo) begin
            up_out_d_d = {HB_LO_CODE, hb_time_q[23:0]};
            up_out_v_d = 1'b1;
        end else if (load_hi) begin
            up_out_d_d = {HB_HI_CODE, hb_time_q[47:24]};
            up_out_v_d = 1'b1;
        end else if (load_data) begin
            up_out_d_d = up_in_d;
            up_out_v_d = 1'b1;
        end else if (free) begin
            up_out_v_d = 1'b0;
        end
    end

    // A pulse landing on the HI-load edge replaces the snapshot being retired.
    always_comb begin
        hb_req       = send_HB_up_pulse && hb_en;
        hb_accept    = hb_req && (!hb_pending_q || load_hi);
        hb_drop      = hb_req && !hb_accept;
        hb_time_d    = hb_accept ? time_ext : hb_time_q;
        hb_pending_d = hb_pending_q;
        if (hb_accept) begin
            hb_pending_d = 1'b1;
        end else if (load_hi) begin
            hb_pending_d = 1'b0;
        end
        drop_cnt_d = drop_cnt_q;
        if (hb_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_time_q    <= '0;
            hb_pending_q <= 1'b0;
            up_out_d_q   <= '0;
            up_out_v_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            hb_time_q    <= hb_time_d;
            hb_pending_q <= hb_pending_d;
            up_out_d_q   <= up_out_d_d;
            up_out_v_q   <= up_out_v_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign up_out_d      = up_out_d_q;
    assign up_out_v      = up_out_v_q;
    assign hb_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_hb_up_serializer.sv
// Directed bench for hb_up_serializer: heartbeat pair framing, merge order,
// back-pressure, drop counting and reset abort.
module tb_hb_up_serializer;

    logic        clk;
    logic        reset;
    logic        send_HB_up_pulse;
    logic [47:0] time_elapsed;
    logic        hb_en;
    logic [31:0] up_in_d;
    logic        up_in_v;
    logic        up_in_a;
    logic [31:0] up_out_d;
    logic        up_out_v;
    logic        up_out_a;
    logic [7:0]  hb_drop_count;

    int n_cmp = 0;
    int n_bad = 0;

    hb_up_serializer dut (
        .clk              (clk),
        .reset            (reset),
        .send_HB_up_pulse (send_HB_up_pulse),
        .time_elapsed     (time_elapsed),
        .hb_en            (hb_en),
        .up_in_d          (up_in_d),
        .up_in_v          (up_in_v),
        .up_in_a          (up_in_a),
        .up_out_d         (up_out_d),
        .up_out_v         (up_out_v),
        .up_out_a         (up_out_a),
        .hb_drop_count    (hb_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        send_HB_up_pulse = 1'b0;
        time_elapsed     = '0;
        hb_en            = 1'b1;
        up_in_d          = '0;
        up_in_v          = 1'b0;
        up_out_a         = 1'b1;
        #2;
        check("rst_v", up_out_v, 0);
        check("rst_d", up_out_d, 0);
        check("rst_drop", hb_drop_count, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_in_a", up_in_a, 1);
    endtask

    logic [31:0] outs[$];
    logic [31:0] exp2[22];
    int          nxt;
    bit          acc;

    initial begin
        // Basic heartbeat framing
        do_reset();
        time_elapsed     = 48'h0000_1234_5678;
        send_HB_up_pulse = 1'b1;
        tick();
        send_HB_up_pulse = 1'b0;
        check("t1_e0_in_a", up_in_a, 0);
        check("t1_e0_v", up_out_v, 0);
        tick();
        check("t1_lo_v", up_out_v, 1);
        check("t1_lo_d", up_out_d, 32'hE034_5678);
        check("t1_lo_in_a", up_in_a, 0);
        tick();
        check("t1_hi_v", up_out_v, 1);
        check("t1_hi_d", up_out_d, 32'hE100_0012);
        check("t1_hi_in_a", up_in_a, 1);
        tick();
        check("t1_e3_v", up_out_v, 0);
        check("t1_drop", hb_drop_count, 0);

        // Continuous data 1..20 with a pulse in cycle 5
        for (int i = 0; i < 6; i++) exp2[i] = 32'(i + 1);
        exp2[6] = 32'hE001_2345;
        exp2[7] = 32'hE1AB_CDEF;
        for (int i = 8; i < 22; i++) exp2[i] = 32'(i - 1);
        time_elapsed = 48'hABCD_EF01_2345;
        nxt     = 1;
        up_in_v = 1'b1;
        up_in_d = 32'd1;
        for (int c = 0; c < 60 && outs.size() < 22; c++) begin
            send_HB_up_pulse = (c == 5);
            #1;
            acc = up_in_a && up_in_v;
            tick();
            if (up_out_v && up_out_a) outs.push_back(up_out_d);
            if (acc) nxt++;
            up_in_v = (nxt <= 20);
            up_in_d = 32'(nxt);
        end
        send_HB_up_pulse = 1'b0;
        up_in_v          = 1'b0;
        check("t2_count", outs.size(), 22);
        for (int i = 0; i < 22 && i < outs.size(); i++) begin
            check($sformatf("t2_word%0d", i), outs[i], exp2[i]);
        end
        repeat (2) tick();
        check("t2_idle_v", up_out_v, 0);

        // Back-pressure on LO, a dropped pulse, then a pulse on the HI-load edge
        time_elapsed     = 48'h0000_5555_AAAA;
        send_HB_up_pulse = 1'b1;
        tick();
        send_HB_up_pulse = 1'b0;
        up_out_a         = 1'b0;
        tick();
        check("t3_lo_d", up_out_d, 32'hE055_AAAA);
        check("t3_lo_v", up_out_v, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                time_elapsed     = 48'hFFFF_FFFF_FFFF;
                send_HB_up_pulse = 1'b1;
            end
            tick();
            send_HB_up_pulse = 1'b0;
            check($sformatf("t3_hold_d%0d", i), up_out_d, 32'hE055_AAAA);
            check($sformatf("t3_hold_v%0d", i), up_out_v, 1);
            check($sformatf("t3_hold_in_a%0d", i), up_in_a, 0);
        end
        check("t3_drop1", hb_drop_count, 1);
        up_out_a         = 1'b1;
        time_elapsed     = 48'h1111_2222_3333;
        send_HB_up_pulse = 1'b1;
        tick();
        send_HB_up_pulse = 1'b0;
        check("t3_hi_d", up_out_d, 32'hE100_0055);
        check("t3_hi_in_a", up_in_a, 0);
        tick();
        check("t3_lo2_d", up_out_d, 32'hE022_3333);
        tick();
        check("t3_hi2_d", up_out_d, 32'hE111_1122);
        tick();
        check("t3_end_v", up_out_v, 0);
        check("t3_drop_end", hb_drop_count, 1);

        // hb_en low ignores pulses; later saturate the drop counter
        do_reset();
        hb_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_HB_up_pulse = 1'b1;
            tick();
            send_HB_up_pulse = 1'b0;
            check($sformatf("t5_off_v%0d", i), up_out_v, 0);
            tick();
            check($sformatf("t5_off_v%0db", i), up_out_v, 0);
        end
        check("t5_off_drop", hb_drop_count, 0);
        hb_en    = 1'b1;
        up_out_a = 1'b0;
        send_HB_up_pulse = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        send_HB_up_pulse = 1'b0;
        check("t5_sat_drop", hb_drop_count, 255);

        // Reset during SEND_HI aborts the heartbeat
        do_reset();
        time_elapsed     = 48'h0000_1234_5678;
        send_HB_up_pulse = 1'b1;
        tick();
        send_HB_up_pulse = 1'b0;
        tick();
        check("t6_lo_d", up_out_d, 32'hE034_5678);
        reset = 1'b0;
        #1;
        check("t6_abort_v", up_out_v, 0);
        check("t6_abort_d", up_out_d, 0);
        tick();
        reset   = 1'b1;
        up_in_v = 1'b1;
        up_in_d = 32'hDEAD_0001;
        #1;
        check("t6_in_a", up_in_a, 1);
        tick();
        up_in_v = 1'b0;
        check("t6_data_v", up_out_v, 1);
        check("t6_data_d", up_out_d, 32'hDEAD_0001);
        tick();
        check("t6_after_v", up_out_v, 0);
        tick();
        check("t6_after_v2", up_out_v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
